// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - opcode/funct3 constants and FSM state encoding shared by the lsu files
package lsu_pkg;

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  localparam logic [2:0] FUNCT3_SB = 3'b000;
  localparam logic [2:0] FUNCT3_SH = 3'b001;
  localparam logic [2:0] FUNCT3_SW = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - request decode, store lane steering/strobes and load extraction/extension
module lsu_align
  import lsu_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic        is_load,
  output logic        err_illegal,
  output logic        err_misaligned,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_val
);
  logic        is_store;
  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  always_comb begin
    is_load  = (opcode == OPCODE_LOAD);
    is_store = (opcode == OPCODE_STORE);
    err_illegal = 1'b1;
    if (is_load) begin
      case (funct3)
        FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU: err_illegal = 1'b0;
        default: err_illegal = 1'b1;
      endcase
    end else if (is_store) begin
      case (funct3)
        FUNCT3_SB, FUNCT3_SH, FUNCT3_SW: err_illegal = 1'b0;
        default: err_illegal = 1'b1;
      endcase
    end
    // funct3[1:0] encodes the access size for every legal load/store
    err_misaligned = !err_illegal &&
                     (((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00)));
  end

  always_comb begin
    wdata = 32'h0;
    wstrb = 4'b0000;
    if (is_store && !err_illegal) begin
      case (funct3)
        FUNCT3_SB: begin
          wdata = {4{store_data[7:0]}};
          wstrb = 4'b0001 << addr_lo;
        end
        FUNCT3_SH: begin
          wdata = {2{store_data[15:0]}};
          wstrb = 4'b0011 << {addr_lo[1], 1'b0};
        end
        default: begin
          wdata = store_data;
          wstrb = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    byte_sh = rdata >> {ld_addr_lo, 3'b000};
    half_sh = rdata >> {ld_addr_lo[1], 4'b0000};
    case (ld_funct3)
      FUNCT3_LB:  load_val = {{24{byte_sh[7]}}, byte_sh[7:0]};
      FUNCT3_LH:  load_val = {{16{half_sh[15]}}, half_sh[15:0]};
      FUNCT3_LW:  load_val = rdata;
      FUNCT3_LBU: load_val = {24'h0, byte_sh[7:0]};
      FUNCT3_LHU: load_val = {16'h0, half_sh[15:0]};
      default:    load_val = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit: request capture, single bus transaction, timeout, completion pulse
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] instruction,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err_misaligned,
  output logic        err_illegal,
  output logic        err_timeout,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);
  localparam logic [31:0] TMO = TIMEOUT_CYCLES;

  lsu_state_e  state_q, state_d;
  logic        is_load_q, is_load_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] tmo_q, tmo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] load_data_q, load_data_d;
  logic        err_mis_q, err_mis_d;
  logic        err_ill_q, err_ill_d;
  logic        err_tmo_q, err_tmo_d;

  logic        dec_is_load, dec_ill, dec_mis;
  logic [31:0] dec_wdata, ld_val;
  logic [3:0]  dec_wstrb;
  logic        handshake, tmo_hit;
  logic        unused_instr_bits;

  assign unused_instr_bits = ^{instruction[31:15], instruction[11:7]};

  lsu_align u_align (
    .opcode         (instruction[6:0]),
    .funct3         (instruction[14:12]),
    .addr_lo        (addr[1:0]),
    .store_data     (store_data),
    .ld_funct3      (funct3_q),
    .ld_addr_lo     (addr_lo_q),
    .rdata          (mem_rdata),
    .is_load        (dec_is_load),
    .err_illegal    (dec_ill),
    .err_misaligned (dec_mis),
    .wdata          (dec_wdata),
    .wstrb          (dec_wstrb),
    .load_val       (ld_val)
  );

  assign handshake = (state_q == ST_BUS) && mem_valid_q && mem_ready;
  assign tmo_hit   = (TMO != 32'd0) && ((tmo_q + 32'd1) == TMO);

  always_comb begin
    state_d     = state_q;
    is_load_d   = is_load_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    mem_addr_d  = mem_addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    tmo_d       = tmo_q;
    mem_valid_d = mem_valid_q;
    load_data_d = load_data_q;
    err_mis_d   = err_mis_q;
    err_ill_d   = err_ill_q;
    err_tmo_d   = err_tmo_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_load_d  = dec_is_load;
          funct3_d   = instruction[14:12];
          addr_lo_d  = addr[1:0];
          mem_addr_d = {addr[31:2], 2'b00};
          wdata_d    = dec_wdata;
          wstrb_d    = dec_wstrb;
          tmo_d      = 32'd0;
          err_ill_d  = dec_ill;
          err_mis_d  = dec_mis;
          err_tmo_d  = 1'b0;
          if (dec_ill || dec_mis) begin
            state_d     = ST_RESP;
            done_d      = 1'b1;
            load_data_d = 32'h0;
          end else begin
            state_d     = ST_BUS;
            mem_valid_d = 1'b1;
          end
        end
      end
      ST_BUS: begin
        // a handshake on the timeout edge still counts as success
        if (handshake) begin
          state_d     = ST_RESP;
          mem_valid_d = 1'b0;
          done_d      = 1'b1;
          load_data_d = is_load_q ? ld_val : 32'h0;
        end else if (tmo_hit) begin
          state_d     = ST_RESP;
          mem_valid_d = 1'b0;
          done_d      = 1'b1;
          err_tmo_d   = 1'b1;
          load_data_d = 32'h0;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        err_ill_d = 1'b0;
        err_mis_d = 1'b0;
        err_tmo_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      is_load_q   <= 1'b0;
      funct3_q    <= 3'd0;
      addr_lo_q   <= 2'd0;
      mem_addr_q  <= 32'h0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
      tmo_q       <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_valid_q <= 1'b0;
      load_data_q <= 32'h0;
      err_mis_q   <= 1'b0;
      err_ill_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_load_q   <= is_load_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      mem_addr_q  <= mem_addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      tmo_q       <= tmo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_valid_q <= mem_valid_d;
      load_data_q <= load_data_d;
      err_mis_q   <= err_mis_d;
      err_ill_q   <= err_ill_d;
      err_tmo_q   <= err_tmo_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign load_data      = load_data_q;
  assign err_misaligned = err_mis_q;
  assign err_illegal    = err_ill_q;
  assign err_timeout    = err_tmo_q;
  assign mem_valid      = mem_valid_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = wdata_q;
  assign mem_wstrb      = wstrb_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - randomized scoreboard bench for lsu against a byte-level reference model
module tb_lsu;
  localparam int TMO = 4;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] instruction = 32'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        busy, done;
  logic [31:0] load_data;
  logic        err_misaligned, err_illegal, err_timeout;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;

  lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .instruction(instruction),
    .addr(addr), .store_data(store_data), .busy(busy), .done(done),
    .load_data(load_data), .err_misaligned(err_misaligned), .err_illegal(err_illegal),
    .err_timeout(err_timeout), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    int          nvalid;
    logic [31:0] load_data;
    logic        ei, em, et;
    logic        bus;
    logic [31:0] baddr, bwdata;
    logic [3:0]  bstrb;
    int          issue;
  } exp_t;

  exp_t resp_q[$];
  int   total = 0;
  int   bad = 0;
  int   neg_count = 0;
  int   nvalid = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: access size in bytes, lane offset, replicated store bytes, masked/extended load.
  function automatic exp_t model(input logic [31:0] instr, input logic [31:0] a,
                                 input logic [31:0] sd, input logic [31:0] rd, input int w);
    exp_t e;
    logic [6:0] opc;
    logic [2:0] f3;
    logic ld, st, legal;
    int nb, lane;
    logic [31:0] mask, v;
    opc = instr[6:0];
    f3 = instr[14:12];
    ld = (opc == OP_LD);
    st = (opc == OP_ST);
    nb = 1 << f3[1:0];
    lane = int'(a[1:0]);
    legal = (ld && (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) || (st && f3 <= 2);
    e.ei = !legal;
    e.em = legal && ((a % nb) != 0);
    e.et = 1'b0;
    e.load_data = 32'h0;
    e.bus = 1'b0;
    e.baddr = 32'h0;
    e.bwdata = 32'h0;
    e.bstrb = 4'h0;
    e.issue = 0;
    if (e.ei || e.em) begin
      e.lat = 1;
      e.nvalid = 0;
      return e;
    end
    e.bus = 1'b1;
    e.baddr = a & ~32'h3;
    if (st) begin
      for (int i = 0; i < 4; i++) begin
        e.bwdata[8*i +: 8] = sd[8*(i % nb) +: 8];
        if (i >= lane && i < lane + nb) e.bstrb[i] = 1'b1;
      end
    end
    if (w >= TMO) begin
      e.et = 1'b1;
      e.lat = TMO + 1;
      e.nvalid = TMO;
      return e;
    end
    e.lat = w + 2;
    e.nvalid = w + 1;
    if (ld) begin
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
      v = (rd >> (8*lane)) & mask;
      if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~mask;
      e.load_data = v;
    end
    return e;
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
    logic [31:0] r;
    r = $urandom;
    r[6:0] = opc;
    r[14:12] = f3;
    return r;
  endfunction

  // Monitor: bus contents every mem_valid cycle, full response on every done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      neg_count++;
      if (!reset_n) begin
        nvalid = 0;
      end else begin
        if (mem_valid) begin
          nvalid++;
          if (resp_q.size() == 0) check("valid_unexpected", 32'(mem_valid), 32'd0);
          else if (resp_q[0].bus) begin
            check("mem_addr", mem_addr, resp_q[0].baddr);
            check("mem_wdata", mem_wdata, resp_q[0].bwdata);
            check("mem_wstrb", 32'(mem_wstrb), 32'(resp_q[0].bstrb));
          end
        end
        if (done) begin
          if (resp_q.size() == 0) check("done_unexpected", 32'(done), 32'd0);
          else begin
            e = resp_q.pop_front();
            check("latency", 32'(neg_count - e.issue - 1), 32'(e.lat));
            check("valid_cycles", 32'(nvalid), 32'(e.nvalid));
            check("load_data", load_data, e.load_data);
            check("err_illegal", 32'(err_illegal), 32'(e.ei));
            check("err_misaligned", 32'(err_misaligned), 32'(e.em));
            check("err_timeout", 32'(err_timeout), 32'(e.et));
            check("busy_at_done", 32'(busy), 32'd1);
          end
          nvalid = 0;
        end
      end
    end
  end

  task automatic run(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] sd,
                     input logic [31:0] rd, input int w, input int stray);
    exp_t e;
    e = model(instr, a, sd, rd, w);
    @(posedge clk); #1;
    instruction = instr;
    addr = a;
    store_data = sd;
    start = 1'b1;
    mem_ready = 1'b0;
    e.issue = neg_count;
    resp_q.push_back(e);
    for (int j = 1; j <= e.lat; j++) begin
      @(posedge clk); #1;
      start = (j == stray);
      if (j == stray) begin
        instruction = $urandom;
        addr = $urandom;
        store_data = $urandom;
      end
      mem_ready = (j > w);
      mem_rdata = (j == w + 1) ? rd : $urandom;
    end
    @(posedge clk); #1;
    start = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] opc;
    exp_t e;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_errs", {29'h0, err_illegal, err_misaligned, err_timeout}, 32'h0);
    reset_n = 1'b1;

    run(mk(OP_LD, 3'b010), 32'h0000_1004, $urandom, 32'hDEAD_BEEF, 0, 0);
    run(mk(OP_LD, 3'b000), 32'h0000_0103, $urandom, 32'h80FF_0000, 0, 0);
    run(mk(OP_LD, 3'b100), 32'h0000_0103, $urandom, 32'h80FF_0000, 1, 0);
    run(mk(OP_ST, 3'b001), 32'h0000_0022, 32'h1234_ABCD, $urandom, 0, 0);
    run(mk(OP_LD, 3'b010), 32'h0000_1002, $urandom, $urandom, 0, 0);
    run(mk(OP_ST, 3'b011), 32'h0000_0040, $urandom, $urandom, 0, 0);
    run(mk(OP_LD, 3'b010), 32'h0000_0100, $urandom, $urandom, 9, 2);
    run(mk(OP_LD, 3'b001), 32'h0000_0202, $urandom, 32'h8001_7FFF, TMO - 1, 1);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) opc = 7'($urandom);
      else opc = $urandom_range(0, 1) ? OP_LD : OP_ST;
      run(mk(opc, 3'($urandom_range(0, 7))), $urandom, $urandom, $urandom,
          ($urandom_range(0, 7) == 0) ? $urandom_range(TMO, TMO + 2) : $urandom_range(0, TMO - 1),
          $urandom_range(0, 4));
    end

    // SW with three wait states, reset during the second wait cycle
    e = model(mk(OP_ST, 3'b010), 32'h0000_0300, 32'hCAFE_F00D, 32'h0, 3);
    @(posedge clk); #1;
    instruction = mk(OP_ST, 3'b010);
    addr = 32'h0000_0300;
    store_data = 32'hCAFE_F00D;
    start = 1'b1;
    mem_ready = 1'b0;
    e.issue = neg_count;
    resp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    resp_q.delete();
    check("rst_mid_valid", 32'(mem_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    run(mk(OP_LD, 3'b010), 32'h0000_0300, $urandom, 32'h1357_9BDF, 1, 0);

    repeat (5) @(posedge clk);
    #1;
    check("pending_responses", 32'(resp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the crush RV32I core, directly downstream of the ALU. It takes the ALU's `out` as the effective address (rs1 + immediate), together with the instruction word and the rs2 value. It runs a single valid/ready transaction on the data-memory bus, steering byte lanes and write strobes for stores and sign/zero-extending the returned data for loads. It reports completion to the writeback/control logic with a one-cycle `done` pulse.

## Interface
- `TIMEOUT_CYCLES`, default 255: number of consecutive cycles the block waits in BUS with `mem_ready` low before aborting. 0 disables the timeout.

- `clk`  in  1  core clock; all logic on the rising edge
- `reset_n`  in  1  reset, synchronous, active-low
- `start`  in  1  request strobe; sampled only in IDLE
- `instruction`  in  32  instruction word (opcode, funct3)
- `addr`  in  32  effective address from the ALU `out`
- `store_data`  in  32  rs2 value
- `busy`  out  1  high whenever the state is not IDLE
- `done`  out  1  one-cycle completion pulse
- `load_data`  out  32  extended load result; valid while `done` is high
- `err_misaligned`, `err_illegal`, `err_timeout`  out  1 each  error flags, valid only with `done`
- `mem_valid`  out  1  bus request
- `mem_ready`  in  1  bus accept/complete
- `mem_addr`  out  32  word-aligned address, {addr[31:2], 2'b00}
- `mem_wdata`  out  32  lane-steered store data
- `mem_wstrb`  out  4  byte enables; 4'b0000 for loads
- `mem_rdata`  in  32  read data; sampled on the handshake edge

## Operation
- States and transitions:
  - IDLE: on `start`, capture `instruction[14:12]`, opcode, `addr[1:0]`, `mem_addr`, `mem_wdata` and `mem_wstrb`.
    - Legal and aligned request goes to BUS.
    - Illegal or misaligned request goes to RESP with the matching error flag and no bus activity.
  - BUS: `mem_valid` = 1.
    - Handshake (`mem_valid && mem_ready` at an edge) goes to RESP; for loads, capture `mem_rdata` on that edge.
    - Timeout goes to RESP with `err_timeout`.
  - RESP: `done` = 1, then go to IDLE unconditionally.
- Legal opcodes are LOAD (7'b0000011) and STORE (7'b0100011); any other opcode sets `err_illegal`.
- Legal funct3 values:
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
  - Any other funct3 sets `err_illegal`.
- Alignment: a halfword access needs `addr[0]` = 0; a word access needs `addr[1:0]` = 0. Otherwise `err_misaligned` is set (illegal is checked first).
- Byte lanes are little-endian: lane n is bits [8n+7:8n].
  - SB: the byte is replicated to all lanes; `mem_wstrb` = 4'b0001 << `addr[1:0]`.
  - SH: the halfword is replicated; `mem_wstrb` = 4'b0011 << {`addr[1]`, 1'b0}.
  - SW: `mem_wstrb` = 4'b1111.
- Loads select the lane(s) by `addr[1:0]`. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- `load_data` is 0 on stores and on any error. It holds its value between `done` pulses.
- `mem_addr`, `mem_wdata` and `mem_wstrb` are stable for the whole BUS state; `mem_valid` is never withdrawn except on timeout or reset.

## Timing
- Reset (`reset_n` low at an edge) puts the block in IDLE with all outputs 0, including `mem_addr`, `load_data` and the timeout counter. This applies in any state.
- Reset mid-BUS drops `mem_valid` on the next cycle; an in-flight memory response is ignored.
- With zero wait states, `start` sampled at edge 0 gives `mem_valid` high in cycle 1, the handshake at edge 1, and `done` in cycle 2. Latency is 2 cycles; throughput is one access per 3 cycles.
- Each wait cycle (`mem_ready` low) adds 1 cycle of latency.
- An error detected in IDLE gives `done` in cycle 1 (latency 1).
- The timeout counter resets on BUS entry and increments each BUS cycle without a handshake. When it reaches `TIMEOUT_CYCLES`, the block goes to RESP.
- A handshake on the same edge as the timeout is treated as success.
- `start` while `busy` is ignored and not queued.

## Structure
- Add `OPCODE_LOAD`, `OPCODE_STORE`, `FUNCT3_LB/LH/LW/LBU/LHU` and `FUNCT3_SB/SH/SW` to the shared `params.vh`, alongside the existing opcode/funct3 constants.
- Add a state encoding for IDLE/BUS/RESP to the same file.
- One combinational sub-module, `lsu_align`: store lane steering and strobe generation, load extraction and extension, and the misaligned/illegal decode. The FSM, capture registers and timeout counter stay in `lsu`.

## Test plan
- LW, `addr` = 0x0000_1004, `mem_rdata` = 0xDEAD_BEEF, `mem_ready` held high:
  - `mem_addr` = 0x0000_1004, `mem_wstrb` = 0.
  - `done` 2 cycles after `start`, `load_data` = 0xDEAD_BEEF.
- LB/LBU at `addr[1:0]` = 2'b11 with `mem_rdata` = 0x80FF_0000:
  - LB gives `load_data` = 0xFFFF_FF80; LBU gives 0x0000_0080.
- SH, `addr` = 0x22, `store_data` = 0x1234_ABCD:
  - `mem_addr` = 0x20, `mem_wdata` = 0xABCD_ABCD, `mem_wstrb` = 4'b1100.
- LW at `addr` = 0x1002 and SB with funct3 = 011:
  - `done` 1 cycle after `start`, with `err_misaligned` and `err_illegal` respectively.
  - `mem_valid` never asserts.
- `TIMEOUT_CYCLES` = 4, `mem_ready` stuck low:
  - `mem_valid` high for exactly 4 cycles, then `done` with `err_timeout`, `load_data` = 0.
  - A second `start` pulsed during BUS is ignored.
- SW with 3 wait states, `reset_n` pulsed low in the 2nd wait cycle:
  - `mem_valid` = 0 and `busy` = 0 on the next cycle; no `done`.
  - A following LW completes normally.
